serial_word_collector: RTL
==========================

Name: serial_word_collector

Overview:
- Downstream consumer of the 4-bit shift register's serial output (q[0]).
- Re-assembles the serial stream into WIDTH-bit words and presents each word on a valid/ready output with a one-entry holding buffer.
- Sits between the shifter and any word-level sink (checker, scoreboard, register file).

Parameters:
- WIDTH, 4, bits per assembled word (2..16).
- MSB_FIRST, 1, 1 = first received bit lands in word_out[WIDTH-1]; 0 = first bit lands in word_out[0].

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-high (block is held in reset while rst_n=1).
- bit_in  input  1  serial data bit from shifter q[0].
- bit_valid  input  1  bit_in sampled on rising clk edge when 1.
- word_out  output  WIDTH  assembled word held in output buffer.
- word_valid  output  1  output buffer holds an unconsumed word.
- word_ready  input  1  sink accepts word_out on rising edge when word_valid=1.
- bit_cnt  output  clog2(WIDTH)+1  bits collected into current partial word.
- overflow  output  1  sticky: a completed word was dropped.

Behaviour:
- Reset (rst_n=1, async): word_out=0, word_valid=0, bit_cnt=0, overflow=0, shift accumulator=0, FSM=IDLE.
- States:
  - IDLE: bit_cnt=0, no partial word. Moves to COLLECT on the first accepted bit.
  - COLLECT: accumulating. Stays while bit_cnt < WIDTH-1 after the accept.
  - Word completion: on the WIDTH-th accepted bit, the word transfers to the output buffer. FSM returns to IDLE on that same edge, so a back-to-back bit on the next cycle starts a new word.
- Accept: one bit per edge where bit_valid=1. bit_valid=0 freezes the accumulator and bit_cnt.
- Latency: word_out and word_valid update on the same edge that accepts the last bit, so they are visible in the following cycle.
- Handshake:
  - word_valid stays 1 and word_out stays stable until an edge with word_ready=1.
  - word_ready while word_valid=0 is ignored.
- Simultaneous pop + completion on one edge: the new word is loaded, word_valid stays 1, no overflow.
- Completion while the buffer is full and word_ready=0:
  - The new word is discarded and the buffer keeps the old word.
  - overflow is set to 1 and stays 1 until reset.
  - bit_cnt still returns to 0.
- Bit order: MSB_FIRST=1 shifts left, inserting at bit 0. MSB_FIRST=0 shifts right, inserting at bit WIDTH-1.
- Reset mid-word: the partial word is discarded, with no output.
- No X propagation: bit_in is ignored when bit_valid=0.

Optional Feature:
- Macro: SERIAL_COLLECTOR_PARITY_EN.
- Defined:
  - Each word is followed by one even-parity bit, giving WIDTH+1 accepted bits per word. Completion occurs on the parity bit.
  - Adds output parity_err (1 bit). It is registered alongside word_out and valid while word_valid=1.
  - parity_err=1 when XOR(data bits, parity bit) != 0. The word is still delivered.
  - bit_cnt width grows to cover WIDTH+1.
- Undefined: no parity bit, no parity_err port, behaviour as above.

Decomposition:
- Package serial_collector_pkg:
  - FSM state enum (IDLE, COLLECT).
  - Function returning the bit_cnt width from WIDTH.
  - Localparam for bits-per-frame (WIDTH or WIDTH+1 under the macro).
- Sub-module word_hold_buf: the one-entry valid/ready output buffer. It owns word_out, word_valid and overflow, and receives a load strobe plus data from the collector.

Test Plan:
- WIDTH=4, MSB_FIRST=1, bits 1,0,1,1 on consecutive cycles, word_ready=0 -> word_out=4'hB, word_valid=1 the cycle after the 4th bit, held until word_ready pulses, then word_valid=0.
- MSB_FIRST=0, same bits 1,0,1,1 -> word_out=4'hD.
- bit_valid gaps: bits 1,(gap 3 cycles),1,(gap),0,0 -> bit_cnt steps 1,2,3 and holds during gaps; word_out=4'hC.
- Overflow: send 0xA, leave word_ready=0, then send 0x5 -> word_out stays 4'hA and overflow=1. Pulse word_ready -> word_valid=0, overflow remains 1.
- Simultaneous: buffer holds 0x3, last bit of 0x6 arrives on the edge with word_ready=1 -> word_out=4'h6, word_valid=1, overflow=0.
- Reset mid-word: after 2 bits, raise rst_n to 1 for 10 ns asynchronously -> bit_cnt=0, word_valid=0, overflow=0. Next 4 bits 0,1,1,1 -> word_out=4'h7. With SERIAL_COLLECTOR_PARITY_EN: 1,0,1,1 + parity 0 -> parity_err=1.

Source files
------------

// File: rtl/serial_collector_pkg.sv
// ============================================================================
// serial_collector_pkg : shared types and sizing helpers for serial_word_collector
// Optional build macro : SERIAL_COLLECTOR_PARITY_EN (adds a trailing parity bit)
// Revision             : 1.0 initial release
// ============================================================================
`default_nettype none

package serial_collector_pkg;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      COLLECT = 1'b1
   } state_t;

   // Extra serial bits appended to every word beyond the data payload.
`ifdef SERIAL_COLLECTOR_PARITY_EN
   localparam int unsigned FRAME_EXTRA = 1;
`else
   localparam int unsigned FRAME_EXTRA = 0;
`endif

   function automatic int unsigned frame_bits(input int unsigned width);
      return width + FRAME_EXTRA;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned width);
      return $clog2(frame_bits(width)) + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/serial_word_collector_word_hold_buf.sv
// ============================================================================
// word_hold_buf : one-entry valid/ready holding buffer with sticky drop flag
// Revision      : 1.0 initial release
// ============================================================================
`default_nettype none

module word_hold_buf #(
   parameter int DW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [DW-1:0] load_data,
   input  logic          ready,
   output logic [DW-1:0] data,
   output logic          valid,
   output logic          overflow
);

   // A load succeeds when the slot is empty or is being drained on the same edge.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         data     <= '0;
         valid    <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (load) begin
            if (!valid || ready) begin
               data  <= load_data;
               valid <= 1'b1;
            end else begin
               overflow <= 1'b1;
            end
         end else if (valid && ready) begin
            valid <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/serial_word_collector.sv
// ============================================================================
// serial_word_collector : assembles a serial bit stream into WIDTH-bit words
// Optional build macro  : SERIAL_COLLECTOR_PARITY_EN (even parity bit per word)
// Revision              : 1.0 initial release
// ============================================================================
`default_nettype none

module serial_word_collector
   import serial_collector_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            bit_in,
   input  logic                            bit_valid,
   output logic [WIDTH-1:0]                word_out,
   output logic                            word_valid,
   input  logic                            word_ready,
   output logic [cnt_width(WIDTH)-1:0]     bit_cnt,
`ifdef SERIAL_COLLECTOR_PARITY_EN
   output logic                            parity_err,
`endif
   output logic                            overflow
);

   localparam int unsigned FRAME = frame_bits(WIDTH);
   localparam int          CW    = cnt_width(WIDTH);

   state_t             state;
   state_t             state_nxt;
   logic [WIDTH-1:0]   acc;
   logic [WIDTH-1:0]   acc_shift;
   logic               last_bit;
   logic               load;

   assign last_bit = (bit_cnt == CW'(FRAME - 1));

   generate
      if (MSB_FIRST) begin : g_msb_first
         assign acc_shift = {acc[WIDTH-2:0], bit_in};
      end else begin : g_lsb_first
         assign acc_shift = {bit_in, acc[WIDTH-1:1]};
      end
   endgenerate

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bit_valid)             state_nxt = COLLECT;
         COLLECT: if (bit_valid && last_bit) state_nxt = IDLE;
         default:                            state_nxt = IDLE;
      endcase
   end

   always_comb begin
      load = 1'b0;
      case (state)
         COLLECT: load = bit_valid && last_bit;
         default: load = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         acc     <= '0;
         bit_cnt <= '0;
      end else if (bit_valid) begin
         if (last_bit) begin
            acc     <= '0;
            bit_cnt <= '0;
         end else begin
            acc     <= acc_shift;
            bit_cnt <= bit_cnt + CW'(1);
         end
      end
   end

`ifdef SERIAL_COLLECTOR_PARITY_EN
   // The final frame bit is the parity bit, so the payload is already complete in acc.
   logic [WIDTH:0] buf_data;

   word_hold_buf #(
      .DW (WIDTH + 1)
   ) u_hold (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .load_data ({(^acc) ^ bit_in, acc}),
      .ready     (word_ready),
      .data      (buf_data),
      .valid     (word_valid),
      .overflow  (overflow)
   );

   assign word_out   = buf_data[WIDTH-1:0];
   assign parity_err = word_valid & buf_data[WIDTH];
`else
   word_hold_buf #(
      .DW (WIDTH)
   ) u_hold (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .load_data (acc_shift),
      .ready     (word_ready),
      .data      (word_out),
      .valid     (word_valid),
      .overflow  (overflow)
   );
`endif

endmodule

`default_nettype wire
